muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the EX-stage ALU; handles the 8 M-extension ops.
//  Accepts one op per start pulse and runs a radix-2 shift-add / restoring-divide loop.
//  Holds busy for the whole op so the hazard unit stalls IF/ID/EX.
//  Pulses done with the 32-bit result for the EX/MEM register; flush aborts the op.
// PARAMETERS
//  XLEN   32  operand/result width; only 32 supported
//  CNT_W  6   iteration counter width; must hold 0..XLEN
// PORTS
//  clk     in   1   clock, rising edge
//  rstn    in   1   asynchronous active-low reset
//  start   in   1   op request; sampled only in IDLE
//  op      in   3   funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  A       in   32  rs1 operand, captured on accept
//  B       in   32  rs2 operand, captured on accept
//  flush   in   1   abort current op (branch/exception flush)
//  busy    out  1   high in any state except IDLE
//  done    out  1   one-cycle pulse; result valid in that cycle
//  result  out  32  registered result; holds until next done
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, busy=0, done=0, result=0, counter=0.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: start=1 & flush=0 accepts the op.
//    Latch op, abs/unsigned operands and result sign. Go to CALC, counter=0.
//  - CALC: one bit per cycle; counter 0..31; after count 31 go to FIX.
//  - FIX: apply sign correction. Select lo/hi product or quotient/remainder. Load result. Go to DONE.
//  - DONE: done=1 for exactly this cycle, busy=1. Next state IDLE.
//    A start seen in DONE is ignored.
//  Latency: start accepted in cycle 0 -> done in cycle 34 (32 CALC + FIX + DONE).
//  Back-to-back: next start accepted in the cycle after DONE.
//  Signedness:
//  - MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU, DIVU, REMU: unsigned.
//  - Product is 64-bit. MUL returns [31:0]; MULH* return [63:32].
//  - DIV quotient sign = A^B; REM remainder sign = sign of A (truncating division).
//  Special cases resolved in IDLE at accept; skip CALC/FIX, go straight to DONE (done in cycle 1):
//  - B==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
//  - DIV overflow, A=0x80000000 & B=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
//  Flush, any state:
//  - Next state IDLE, busy drops next cycle, no done pulse, result unchanged.
//  - flush=1 with start=1 in IDLE: op not accepted.
//  - flush in DONE: the done already visible this cycle stands.
//  start while busy: ignored, never queued.
//  A and B are sampled only on accept; changes during CALC have no effect.
//  No combinational path from start/A/B to done/result.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN: when defined, more ops short-circuit IDLE -> DONE (done in cycle 1):
//  - MUL* with A==0 or B==0 -> result 0.
//  - DIV/DIVU with A==0 -> 0; REM/REMU with A==0 -> 0.
//  When undefined: these ops take the full 34-cycle path. Results are bit-identical either way.
// TESTING
//  1 MUL A=7 B=-3 (0xFFFFFFFD), start in cyc 0 -> done in cyc 34, result=0xFFFFFFEB; busy high cyc 1..34.
//  2 MULH A=0x80000000 B=0x80000000 -> 0x40000000.
//    MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU A=-1 B=0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV A=-7 B=2 -> 0xFFFFFFFD.
//    REM A=-7 B=2 -> 0xFFFFFFFF.
//    DIVU A=100 B=7 -> 14; REMU A=100 B=7 -> 2.
//  4 DIV A=5 B=0 -> 0xFFFFFFFF, done in cyc 1.
//    REMU A=5 B=0 -> 5.
//    DIV A=0x80000000 B=-1 -> 0x80000000; REM same operands -> 0.
//  5 flush in cyc 10 of a DIVU -> busy=0 from cyc 11, no done.
//    Result keeps its prior value; a new start in cyc 11 completes normally.
//  6 rstn low mid-CALC -> busy/done/result=0 immediately.
//    Start held high while busy is ignored.
//    MUL A=0 B=9: done cyc 1 with MULDIV_EARLY_OUT_EN defined, cyc 34 without; result 0 both.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if
//   Request/response bundle between the EX stage and the iterative RV32M
//   multiply/divide sequencer.
//
//   start  : op request, sampled only while the sequencer is idle
//   op     : funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   A, B   : rs1 / rs2 operands, captured on accept
//   flush  : abort the current op
//   busy   : high whenever the sequencer is not idle
//   done   : one-cycle pulse, result valid in that cycle
//   result : registered result, holds until the next done
//
//   master modport = EX-stage side, slave modport = sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, A, B, flush, input busy, done, result);
  modport slave  (input start, op, A, B, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Iterative RV32M multiply/divide sequencer. One bit per cycle:
//   radix-2 shift-add multiply or restoring divide on operand magnitudes,
//   followed by a sign-fix cycle. Latency 34 cycles from accept to done;
//   divide-by-zero and signed-overflow divides finish in cycle 1.
//
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : muldiv_seq_if.slave (start, op, A, B, flush / busy, done, result)
//
//   Build option MULDIV_EARLY_OUT_EN: when defined, multiplies with a zero
//   operand and divides/remainders with A==0 also finish in cycle 1.
//   Results are identical with or without it.
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  // Two's-complement negate when s is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic s);
    return s ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic s);
    return s ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;      // sign correction applied in FIX
  logic [XLEN-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;        // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;        // multiplier / dividend -> quotient

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // Operand signedness: MULH/DIV/REM both signed, MULHSU only A.
    sgn_a = bus.A[XLEN-1] & ((bus.op == OP_MULH) | (bus.op == OP_MULHSU) |
                             (bus.op == OP_DIV)  | (bus.op == OP_REM));
    sgn_b = bus.B[XLEN-1] & ((bus.op == OP_MULH) | (bus.op == OP_DIV) |
                             (bus.op == OP_REM));
    a_mag = cond_neg(bus.A, sgn_a);
    b_mag = cond_neg(bus.B, sgn_b);

    // Shift-add step: add multiplicand when the current multiplier bit is set.
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});

    // Restoring-divide step: shift next dividend bit into the remainder.
    rem_sh = {hi_q, lo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, mcand_q};

    prod_fix = cond_neg2({hi_q, lo_q}, neg_q);
    quo_fix  = cond_neg(lo_q, neg_q);
    rem_fix  = cond_neg(hi_q, neg_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          cnt_d  = '0;
          state_d = CALC;
          // Remainder takes the dividend's sign; everything else A^B.
          neg_d  = (bus.op == OP_REM) ? sgn_a : (sgn_a ^ sgn_b);
          hi_d   = '0;
          if (bus.op[2]) begin
            mcand_d = b_mag;
            lo_d    = a_mag;
          end else begin
            mcand_d = a_mag;
            lo_d    = b_mag;
          end
          if (bus.op[2] && (bus.B == '0)) begin
            result_d = bus.op[1] ? bus.A : '1;
            state_d  = DONE;
          end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                       (bus.A == INT_MIN) && (bus.B == '1)) begin
            result_d = bus.op[1] ? '0 : INT_MIN;
            state_d  = DONE;
          end else if (EARLY_OUT &&
                       ((!bus.op[2] && ((bus.A == '0) || (bus.B == '0))) ||
                        (bus.op[2] && (bus.A == '0)))) begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          hi_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[2])            result_d = op_q[1] ? rem_fix : quo_fix;
        else if (op_q == OP_MUL) result_d = prod_fix[XLEN-1:0];
        else                     result_d = prod_fix[2*XLEN-1:XLEN];
        state_d = DONE;
      end
      default: state_d = IDLE;  // DONE
    endcase

    // Flush wins everywhere: back to IDLE, result untouched, nothing accepted.
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    neg_q   <= neg_d;
    mcand_q <= mcand_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus();
  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc++;

  // Reference: RV32M semantics via 64-bit and native SV arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
      3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2] && (a == 0 || b == 0)) return 1;
    if (op[2] && a == 0) return 1;
`endif
    return 34;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops an expectation on every done, otherwise the
  // result register must hold the last delivered value.
  exp_t e;
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("result op%0d a=%08h b=%08h", e.op, e.a, e.b), bus.result, e.res);
          chk($sformatf("latency op%0d a=%08h b=%08h", e.op, e.a, e.b), 32'(cyc - e.acc), 32'(e.lat));
          last_res = e.res;
        end
      end else begin
        chk("result_hold", bus.result, last_res);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    int   t = 0;
    while (bus.busy && t < 200) begin step(); t++; end
    if (t >= 200) chk("idle_timeout", 32'd1, 32'd0);
    bus.op = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    x.op = op; x.a = a; x.b = b;
    x.res = ref_res(op, a, b); x.lat = ref_lat(op, a, b); x.acc = cyc;
    sbq.push_back(x);
    step();
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom;  // operands must be ignored after accept
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || bus.busy) && t < 2000) begin step(); t++; end
    if (t >= 2000) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rstn = 1'b1;
    step();

    // MUL 7 * -3, busy across cycles 1..34 and done in 34.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    for (int i = 1; i <= 34; i++) begin
      chk($sformatf("busy_cyc%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("done_cyc%0d", i), 32'(bus.done), 32'(i == 34));
      if (i < 34) step();
    end
    step();
    chk("busy_after_done", 32'(bus.busy), 32'd0);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd7, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd0, 32'd0, 32'd9);
    drain();

    // Flush in cycle 10 of a DIVU, then a new op in cycle 11.
    issue(3'd5, 32'd1000, 32'd3);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    void'(sbq.pop_back());
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_result", bus.result, last_res);
    issue(3'd5, 32'd1000, 32'd3);
    drain();

    // start together with flush in IDLE is not accepted.
    step();
    bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4; bus.start = 1'b1; bus.flush = 1'b1;
    step();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);

    // start held high through the whole op including DONE: one op only.
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.start = 1'b1;
    bus.op = 3'd0; bus.A = 32'd11; bus.B = 32'd13;
    repeat (34) step();
    bus.start = 1'b0;
    drain();
    repeat (3) step();
    chk("held_start_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-CALC.
    issue(3'd4, 32'd12345, 32'd17);
    repeat (10) step();
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    sbq.delete();
    last_res = '0;
    step();
    rstn = 1'b1;
    step();

    // Randomised back-to-back ops.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      issue(rop, ra, rb);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
